ex_mul_unit: RTL and testbench
==============================

Name: ex_mul_unit

Overview:
- Iterative integer multiplier for the EX stage. Executes MULT/MULTU alongside the single-cycle ALU/FPU.
- Accepts operands from the ID/EX pipe register and computes a full 2*WIDTH-bit product over WIDTH/BITS_PER_CYCLE cycles.
- Drives mul_stall, which freezes IF/ID and ID/EX until the product is ready.
- The low word is captured into EX/MEM in the cycle result_valid is high.

Parameters:
- WIDTH, 32, operand width in bits.
- BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle. Legal values are 1, 2 and 4, and the value must divide WIDTH. N = WIDTH/BITS_PER_CYCLE.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- start  input  1  a multiply instruction is present in EX (decoded from the ID/EX control bits)
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU
- operand_a  input  WIDTH  multiplicand (ex_operand_a)
- operand_b  input  WIDTH  multiplier (ex_operand_b)
- flush  input  1  abort the in-flight multiply (taken branch or jump squash)
- result  output  WIDTH  low WIDTH bits of the product
- result_hi  output  WIDTH  high WIDTH bits of the product
- result_valid  output  1  one-cycle pulse; result and result_hi are final
- busy  output  1  state == RUN
- mul_stall  output  1  pipeline freeze request

Behaviour:
- Reset and clock: reset is synchronous, active-high; clock is clock.
- Reset values:
  - state = IDLE
  - result = 0, result_hi = 0
  - result_valid = 0, busy = 0
  - mul_stall = 0 (forced low while reset is high)
- State machine:
  - IDLE: if start && !flush, latch |operand_a|, |operand_b| (magnitudes when is_signed, raw values otherwise). Latch neg = is_signed & (a[MSB] ^ b[MSB]). Clear the 2*WIDTH accumulator, set count = N, go to RUN. Otherwise stay in IDLE.
  - RUN: each cycle, add (multiplicand * low BITS_PER_CYCLE bits of multiplier) shifted into the accumulator, shift the multiplier right by BITS_PER_CYCLE, and decrement count.
  - RUN exit: when count reaches 1, write the final product (two's-complement negated over 2*WIDTH bits if neg) to result/result_hi and go to DONE.
  - DONE: result_valid = 1 for exactly this cycle; go to IDLE unconditionally. start is ignored here, because it belongs to the completing instruction.
- Latency is fixed and data-independent, with no early-out for zero operands:
  - start sampled in IDLE at cycle 0.
  - RUN occupies cycles 1..N.
  - DONE and result_valid at cycle N+1 (cycle 33 at default parameters).
- mul_stall (combinational) = !reset & !flush & ((state==IDLE & start) | state==RUN).
  - It is high for cycles 0..N and low in DONE, so the pipeline advances exactly once, capturing result.
- result and result_hi hold their value until the next product completes. They are not cleared on flush.
- start while in RUN is ignored; the operands are assumed stable because the pipeline is frozen.
- Flush handling:
  - flush in any state: next state = IDLE, accumulator discarded, no result_valid.
  - flush has priority over start.
- Reset mid-RUN: return to reset values next cycle; no result_valid.
- Signed edge case: 0x80000000 has magnitude 2^31, which fits unsigned WIDTH bits. The full product is always exact in 2*WIDTH bits; no overflow flag.
- Back-to-back multiplies: the second start is seen in the cycle after DONE (state IDLE), so there is one non-stalled gap cycle between products.

Test Plan:
- MULTU 7 x 6, start held: mul_stall high cycles 0-32. At cycle 33: result_valid=1, result=0x0000002A, result_hi=0. At cycle 34: result_valid=0.
- MULT 0xFFFFFFFD (-3) x 5 -> result=0xFFFFFFF1, result_hi=0xFFFFFFFF. Repeat with MULTU -> result=0xFFFFFFF1, result_hi=0x00000004.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> result_hi=0xFFFFFFFE, result=0x00000001. MULT 0x80000000 x 0x80000000 -> result_hi=0x40000000, result=0.
- Flush in cycle 10 of a multiply: mul_stall low that cycle, busy=0 next cycle, no result_valid, prior result unchanged. A fresh start of 3x4 then yields 0x0000000C after 33 cycles.
- Reset asserted mid-RUN at cycle 15, with start held high during reset: all outputs 0 and mul_stall=0 while reset is high. After release, a restart completes normally.
- Start held high through DONE, then a second MULTU 2x9 on the following cycle: exactly one result_valid per product. The second product is 0x00000012, with result_valid 34 cycles after the first.
- Repeat all of the above with BITS_PER_CYCLE=4: same products, result_valid at cycle 9.

Source files
------------

// File: rtl/ex_mul_unit.sv
// Iterative radix-2^BITS_PER_CYCLE integer multiplier for the EX stage.
// Produces a full 2*WIDTH-bit product after WIDTH/BITS_PER_CYCLE RUN cycles and stalls the front end meanwhile.
module ex_mul_unit #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             flush,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             result_valid,
   output logic             busy,
   output logic             mul_stall
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   localparam int PW = WIDTH + BITS_PER_CYCLE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [WIDTH-1:0]     mcand_reg;
   logic [WIDTH-1:0]     mplier_reg;
   logic [2*WIDTH-1:0]   acc_reg;
   logic [CW-1:0]        count_reg;
   logic                 neg_reg;
   logic [WIDTH-1:0]     result_reg;
   logic [WIDTH-1:0]     result_hi_reg;

   logic                 load, step, finish;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [PW-1:0]        pp_term [BITS_PER_CYCLE];
   logic [PW-1:0]        pp_sum;
   logic [PW-1:0]        acc_sum;
   logic [2*WIDTH-1:0]   acc_next;
   logic [2*WIDTH-1:0]   product;

   assign mag_a = (is_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
   assign mag_b = (is_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

   // One shifted copy of the multiplicand per multiplier bit retired this cycle.
   generate
      for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
         assign pp_term[gi] = mplier_reg[gi] ? ({{BITS_PER_CYCLE{1'b0}}, mcand_reg} << gi) : '0;
      end
   endgenerate

   always_comb begin
      pp_sum = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         pp_sum = pp_sum + pp_term[i];
      end
   end

   // Partial products enter at the top half and the accumulator shifts right,
   // so after N steps the low bits of the product have drifted into place.
   assign acc_sum  = {{BITS_PER_CYCLE{1'b0}}, acc_reg[2*WIDTH-1:WIDTH]} + pp_sum;
   assign acc_next = (2*WIDTH)'({acc_sum, acc_reg[WIDTH-1:0]} >> BITS_PER_CYCLE);
   assign product  = neg_reg ? -acc_next : acc_next;

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && !flush) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               state_next = IDLE;
            end else begin
               step = 1'b1;
               if (count_reg == CW'(1)) begin
                  finish     = 1'b1;
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= IDLE;
         mcand_reg     <= '0;
         mplier_reg    <= '0;
         acc_reg       <= '0;
         count_reg     <= '0;
         neg_reg       <= 1'b0;
         result_reg    <= '0;
         result_hi_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (load) begin
            mcand_reg  <= mag_a;
            mplier_reg <= mag_b;
            neg_reg    <= is_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            acc_reg    <= '0;
            count_reg  <= CW'(N);
         end
         if (step) begin
            acc_reg    <= acc_next;
            mplier_reg <= mplier_reg >> BITS_PER_CYCLE;
            count_reg  <= count_reg - CW'(1);
         end
         if (finish) begin
            result_reg    <= product[WIDTH-1:0];
            result_hi_reg <= product[2*WIDTH-1:WIDTH];
         end
      end
   end

   assign result       = result_reg;
   assign result_hi    = result_hi_reg;
   assign result_valid = (state_reg == DONE) && !flush;
   assign busy         = (state_reg == RUN);
   assign mul_stall    = !reset && !flush &&
                         (((state_reg == IDLE) && start) || (state_reg == RUN));

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed and random checks of ex_mul_unit at BITS_PER_CYCLE = 1 and 4
// against an arithmetic product model.
module tb_ex_mul_unit;

   localparam int WIDTH = 32;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        sel = 1'b0;
   logic        start_v = 1'b0;
   logic        is_signed_v = 1'b0;
   logic [31:0] a_v = '0;
   logic [31:0] b_v = '0;
   logic        flush = 1'b0;

   logic [31:0] r1, rh1, r4, rh4;
   logic        v1, bz1, st1, v4, bz4, st4;
   logic [31:0] res, res_hi;
   logic        res_valid, busy, stall;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_valid_cyc = 0;
   logic [63:0] last_exp = '0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   ex_mul_unit #(.WIDTH(WIDTH), .BITS_PER_CYCLE(1)) dut1 (
      .clock(clock), .reset(reset), .start(start_v & ~sel), .is_signed(is_signed_v),
      .operand_a(a_v), .operand_b(b_v), .flush(flush),
      .result(r1), .result_hi(rh1), .result_valid(v1), .busy(bz1), .mul_stall(st1));

   ex_mul_unit #(.WIDTH(WIDTH), .BITS_PER_CYCLE(4)) dut4 (
      .clock(clock), .reset(reset), .start(start_v & sel), .is_signed(is_signed_v),
      .operand_a(a_v), .operand_b(b_v), .flush(flush),
      .result(r4), .result_hi(rh4), .result_valid(v4), .busy(bz4), .mul_stall(st4));

   assign res       = sel ? r4  : r1;
   assign res_hi    = sel ? rh4 : rh1;
   assign res_valid = sel ? v4  : v1;
   assign busy      = sel ? bz4 : bz1;
   assign stall     = sel ? st4 : st1;

   function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      if (s) begin
         sa = $signed(a);
         sb = $signed(b);
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   function automatic int n_steps();
      return sel ? WIDTH / 4 : WIDTH;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s bpc=%0d observed=%h expected=%h", tag, sel ? 4 : 1, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // Issues one multiply and follows it to DONE; returns at the DONE-cycle negedge.
   task automatic run_mul(input bit s, input logic [31:0] a, input logic [31:0] b, input bit hold);
      logic [63:0] exp;
      int lat;
      bit got;
      exp = model(s, a, b);
      lat = n_steps() + 1;
      next_cycle();
      start_v = 1'b1; is_signed_v = s; a_v = a; b_v = b;
      got = 1'b0;
      for (int k = 0; k <= lat + 3 && !got; k++) begin
         if (k > 0) begin
            next_cycle();
            if (!hold) start_v = 1'b0;
         end
         @(negedge clock);
         if (res_valid) begin
            got = 1'b1;
            last_valid_cyc = cyc;
            check("latency", 64'(k), 64'(lat));
            check("stall_done", 64'(stall), 64'd0);
            check("result_lo", 64'(res), 64'(exp[31:0]));
            check("result_hi", 64'(res_hi), 64'(exp[63:32]));
            last_exp = exp;
         end else begin
            check("stall_run", 64'(stall), 64'd1);
         end
      end
      if (!got) check("valid_timeout", 64'd0, 64'd1);
      $display("MUL bpc=%0d %s a=%h b=%h -> hi=%h lo=%h exp=%h", sel ? 4 : 1,
               s ? "MULT " : "MULTU", a, b, res_hi, res, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int cfg = 0; cfg < 2; cfg++) begin
         logic [63:0] prior;
         int first_cyc, fc, rc;
         bit seen;
         sel = cfg[0];
         reset = 1'b1; start_v = 1'b0; flush = 1'b0;
         next_cycle(); next_cycle();
         @(negedge clock);
         check("rst_result", 64'(res), 64'd0);
         check("rst_result_hi", 64'(res_hi), 64'd0);
         check("rst_valid", 64'(res_valid), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
         check("rst_stall", 64'(stall), 64'd0);
         next_cycle();
         reset = 1'b0;

         // 7 x 6 with start held through DONE
         run_mul(1'b0, 32'd7, 32'd6, 1'b1);
         next_cycle();
         start_v = 1'b0;
         @(negedge clock);
         check("valid_after_done", 64'(res_valid), 64'd0);
         check("stall_after_done", 64'(stall), 64'd0);

         run_mul(1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
         run_mul(1'b0, 32'hFFFF_FFFD, 32'd5, 1'b0);
         run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
         run_mul(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);

         // Flush mid-multiply
         prior = last_exp;
         fc = (n_steps() > 12) ? 10 : n_steps() / 2;
         next_cycle();
         start_v = 1'b1; is_signed_v = 1'b0; a_v = 32'h1234; b_v = 32'h5678;
         for (int k = 1; k <= fc; k++) begin
            next_cycle();
            start_v = 1'b0;
         end
         flush = 1'b1;
         @(negedge clock);
         check("flush_stall", 64'(stall), 64'd0);
         check("flush_valid", 64'(res_valid), 64'd0);
         next_cycle();
         flush = 1'b0;
         @(negedge clock);
         check("flush_busy", 64'(busy), 64'd0);
         check("flush_keep_lo", 64'(res), 64'(prior[31:0]));
         check("flush_keep_hi", 64'(res_hi), 64'(prior[63:32]));
         seen = 1'b0;
         for (int k = 0; k < n_steps() + 4; k++) begin
            next_cycle();
            @(negedge clock);
            if (res_valid) seen = 1'b1;
         end
         check("flush_no_valid", 64'(seen), 64'd0);
         run_mul(1'b0, 32'd3, 32'd4, 1'b0);

         // Reset mid-RUN with start held high
         rc = (n_steps() > 16) ? 15 : n_steps() / 2 + 1;
         next_cycle();
         start_v = 1'b1; is_signed_v = 1'b0; a_v = 32'h1111; b_v = 32'h2222;
         for (int k = 1; k <= rc; k++) next_cycle();
         reset = 1'b1;
         @(negedge clock);
         check("midrst_stall_now", 64'(stall), 64'd0);
         for (int k = 0; k < 2; k++) begin
            next_cycle();
            @(negedge clock);
            check("midrst_result", 64'(res), 64'd0);
            check("midrst_result_hi", 64'(res_hi), 64'd0);
            check("midrst_valid", 64'(res_valid), 64'd0);
            check("midrst_busy", 64'(busy), 64'd0);
            check("midrst_stall", 64'(stall), 64'd0);
         end
         next_cycle();
         reset = 1'b0; start_v = 1'b0;
         run_mul(1'b1, 32'hFFFF_FFF9, 32'd9, 1'b0);

         // Back-to-back products, start held through the first DONE
         run_mul(1'b0, 32'd5, 32'd5, 1'b1);
         first_cyc = last_valid_cyc;
         run_mul(1'b0, 32'd2, 32'd9, 1'b0);
         check("b2b_gap", 64'(last_valid_cyc - first_cyc), 64'(n_steps() + 2));

         for (int r = 0; r < 6; r++) begin
            run_mul(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
         end
         next_cycle();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
